// File: rtl/galvo_pkg.sv
// rtl/galvo_pkg.sv - shared FSM state type and default command prefix for galvo_dac_streamer
package galvo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE,
    ST_LDAC
  } state_e;

  localparam logic [3:0] CMD_WORD_DEFAULT = 4'b0011;

endpackage

// File: rtl/galvo_dac_streamer_fifo.sv
// rtl/galvo_dac_streamer_fifo.sv - point_fifo: synchronous first-word-fall-through FIFO with occupancy count
module point_fifo
  import galvo_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/galvo_dac_streamer.sv
// rtl/galvo_dac_streamer.sv - point FIFO plus serial galvo DAC framer with LDAC strobe; optional LASER_DELAY_EN delays laser_out
module galvo_dac_streamer
  import galvo_pkg::*;
#(
  parameter int                  NUM_CH       = 2,
  parameter int                  DAC_BITS     = 12,
  parameter int                  CMD_BITS     = 4,
  parameter logic [CMD_BITS-1:0] CMD_WORD     = CMD_BITS'(CMD_WORD_DEFAULT),
  parameter int                  FIFO_DEPTH   = 16,
  parameter int                  CLK_DIV      = 4,
  parameter int                  POINT_PERIOD = 1000
`ifdef LASER_DELAY_EN
  ,
  parameter int                  LASER_DELAY  = 8
`endif
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             pt_valid,
  output logic                             pt_ready,
  input  logic [NUM_CH*DAC_BITS-1:0]       pt_data,
  input  logic                             pt_laser,
  output logic                             dac_sclk,
  output logic                             dac_cs_n,
  output logic [NUM_CH-1:0]                dac_sdi,
  output logic                             dac_ldac_n,
  output logic                             laser_out,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             underflow
);

  localparam int FRAME_BITS = CMD_BITS + DAC_BITS;
  localparam int PW         = NUM_CH * DAC_BITS;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int TW         = $clog2(POINT_PERIOD);
  localparam int DW         = $clog2(CLK_DIV) + 1;
  localparam int BW         = $clog2(FRAME_BITS) + 1;

  logic [PW:0]   fifo_rdata;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic          push_acc, pop_acc, tick;

  logic [TW-1:0] timer_q, timer_d;
  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [NUM_CH-1:0][FRAME_BITS-1:0] sr_q, sr_d;
  logic [FRAME_BITS-1:0] frame_w;
  logic [NUM_CH-1:0] sdi_q, sdi_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          ldac_n_q, ldac_n_d;
  logic          laser_lat_q, laser_lat_d;
  logic          laser_q, laser_d;
  logic          underflow_q, underflow_d;
  logic          pt_ready_q, pt_ready_d;
`ifdef LASER_DELAY_EN
  logic [LASER_DELAY-1:0] ldly_vld_q, ldly_vld_d;
  logic [LASER_DELAY-1:0] ldly_val_q, ldly_val_d;
`endif

  assign push_acc = pt_valid && pt_ready_q;
  assign pop_acc  = (state_q == ST_LOAD);

  point_fifo #(
    .WIDTH (PW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_acc),
    .wdata ({pt_laser, pt_data}),
    .pop   (pop_acc),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Point timer: free-runs 0..POINT_PERIOD-1 while enabled, tick on wrap.
  always_comb begin
    timer_d = timer_q;
    tick    = 1'b0;
    if (!enable) begin
      timer_d = '0;
    end else if (timer_q == TW'(POINT_PERIOD - 1)) begin
      timer_d = '0;
      tick    = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Frame sequencer: next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | (tick && (state_q != ST_IDLE));
    div_d       = div_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    frame_w     = '0;
    sdi_d       = sdi_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    ldac_n_d    = ldac_n_q;
    laser_lat_d = laser_lat_q;
    laser_d     = laser_q;
    underflow_d = underflow_q;
    pt_ready_d  = fifo_full ? pop_acc
                            : !(push_acc && !pop_acc && (fifo_cnt == CW'(FIFO_DEPTH - 1)));
`ifdef LASER_DELAY_EN
    ldly_vld_d = ldly_vld_q << 1;
    ldly_val_d = ldly_val_q << 1;
    if (ldly_vld_q[LASER_DELAY-1]) laser_d = ldly_val_q[LASER_DELAY-1];
`endif

    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          pending_d = 1'b0;
          if (!fifo_empty) begin
            state_d = ST_LOAD;
          end else begin
            // No point available: hold DAC values, blank the beam at once.
            underflow_d = 1'b1;
            laser_d     = 1'b0;
`ifdef LASER_DELAY_EN
            ldly_vld_d  = '0;
`endif
          end
        end
      end
      ST_LOAD: begin
        for (int c = 0; c < NUM_CH; c++) begin
          frame_w  = {CMD_WORD, fifo_rdata[c*DAC_BITS +: DAC_BITS]};
          sdi_d[c] = frame_w[FRAME_BITS-1];
          sr_d[c]  = frame_w << 1;
        end
        laser_lat_d = fifo_rdata[PW];
        cs_n_d      = 1'b0;
        sclk_d      = 1'b0;
        div_d       = '0;
        bit_d       = '0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          // Data moves only on the falling edge, together with sclk going low.
          if (sclk_q) begin
            if (bit_q == BW'(FRAME_BITS - 1)) begin
              cs_n_d  = 1'b1;
              sdi_d   = '0;
              state_d = ST_DONE;
            end else begin
              bit_d = bit_q + 1'b1;
              for (int c = 0; c < NUM_CH; c++) begin
                sdi_d[c] = sr_q[c][FRAME_BITS-1];
                sr_d[c]  = sr_q[c] << 1;
              end
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d    = '0;
          ldac_n_d = 1'b0;
          state_d  = ST_LDAC;
`ifdef LASER_DELAY_EN
          ldly_vld_d[0] = 1'b1;
          ldly_val_d[0] = laser_lat_q;
`else
          laser_d = laser_lat_q;
`endif
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LDAC: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d    = '0;
          ldac_n_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q     <= '0;
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      sdi_q       <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      ldac_n_q    <= 1'b1;
      laser_lat_q <= 1'b0;
      laser_q     <= 1'b0;
      underflow_q <= 1'b0;
      pt_ready_q  <= 1'b1;
`ifdef LASER_DELAY_EN
      ldly_vld_q  <= '0;
      ldly_val_q  <= '0;
`endif
    end else begin
      timer_q     <= timer_d;
      state_q     <= state_d;
      pending_q   <= pending_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      sdi_q       <= sdi_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      ldac_n_q    <= ldac_n_d;
      laser_lat_q <= laser_lat_d;
      laser_q     <= laser_d;
      underflow_q <= underflow_d;
      pt_ready_q  <= pt_ready_d;
`ifdef LASER_DELAY_EN
      ldly_vld_q  <= ldly_vld_d;
      ldly_val_q  <= ldly_val_d;
`endif
    end
  end

  assign pt_ready   = pt_ready_q;
  assign dac_sclk   = sclk_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_sdi    = sdi_q;
  assign dac_ldac_n = ldac_n_q;
  assign laser_out  = laser_q;
  assign fifo_count = fifo_cnt;
  assign underflow  = underflow_q;

endmodule
